debounce_multi: RTL and testbench



---
 rtl/debounce_multi_pkg.sv | 16 +
 rtl/debounce_chan.sv | 98 +++++++++
 rtl/debounce_multi.sv | 103 ++++++++++
 tb/tb_debounce_multi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel debouncer.
package debounce_multi_pkg;

  typedef enum logic {ST_INIT, ST_RUN} dbm_state_e;

  // Width of a counter that must hold 0..max_val (never narrower than 1 bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Clocks per 1 ms tick.
  function automatic int tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, clean level flop,
// edge pulses and (optionally) long-press detection.
module debounce_chan
  import debounce_multi_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   DEBOUNCE_MS   = 5,
  parameter int   LONG_PRESS_MS = 1000,
  parameter bit   HAS_LONG      = 1'b0,
  parameter logic IDLE          = 1'b0   // db value meaning "inactive"
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic tick,
  input  logic pin,
  output logic db,
  output logic press_ev,
  output logic rel_ev,
  output logic long_ev,
  output logic held
);

  localparam int SCW = cnt_w(DEBOUNCE_MS);
  localparam logic [SCW-1:0] ST_LAST = SCW'(DEBOUNCE_MS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [SCW-1:0]         stable_cnt;
  logic                   accept;
  logic                   active;

  // Synchroniser resets to the idle level so no phantom edge appears after reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= {SYNC_STAGES{IDLE}};
    else       sync <= {sync[SYNC_STAGES-2:0], pin};

  assign s      = sync[SYNC_STAGES-1];
  assign active = db ^ IDLE;
  // The tick that completes the stable window is the one that accepts the new level.
  assign accept = run && (s != db) && tick && (stable_cnt == ST_LAST);

  // Clean level and edge pulses; before RUN the level simply tracks the input.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      db         <= IDLE;
      stable_cnt <= '0;
      press_ev   <= 1'b0;
      rel_ev     <= 1'b0;
    end else begin
      press_ev <= 1'b0;
      rel_ev   <= 1'b0;
      if (!run) begin
        db         <= s;
        stable_cnt <= '0;
      end else if (s == db) begin
        stable_cnt <= '0;
      end else if (accept) begin
        db         <= s;
        stable_cnt <= '0;
        press_ev   <= (s != IDLE);
        rel_ev     <= (s == IDLE);
      end else if (tick) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end

  if (HAS_LONG) begin : g_long
    localparam int HCW = cnt_w(LONG_PRESS_MS);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(LONG_PRESS_MS);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(LONG_PRESS_MS - 1);
    logic [HCW-1:0] hold_cnt;

    // Active-time counter; saturates so pb_long fires once per press.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        hold_cnt <= '0;
        long_ev  <= 1'b0;
        held     <= 1'b0;
      end else begin
        long_ev <= 1'b0;
        if (!run || (accept && (s == IDLE))) begin
          hold_cnt <= '0;
          held     <= 1'b0;
        end else if (active && tick && (hold_cnt != HOLD_MAX)) begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            long_ev <= 1'b1;
            held    <= 1'b1;
          end
        end
      end
  end else begin : g_nolong
    assign long_ev = 1'b0;
    assign held    = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// Button/switch conditioner: shared 1 ms prescaler, INIT/RUN sequencer and
// one debounce_chan per pin.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int              N_PB          = 6,
  parameter int              N_SW          = 16,
  parameter int              CLK_HZ        = 50000000,
  parameter int              DEBOUNCE_MS   = 5,
  parameter int              LONG_PRESS_MS = 1000,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [N_PB-1:0] PB_ACTIVE_LOW = 6'b000001
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N_PB-1:0] pbtn_in,
  input  logic [N_SW-1:0] switch_in,
  output logic [N_PB-1:0] pbtn_db,
  output logic [N_SW-1:0] swtch_db,
  output logic [N_PB-1:0] pb_press,
  output logic [N_PB-1:0] pb_release,
  output logic [N_PB-1:0] pb_long,
  output logic [N_PB-1:0] pb_held,
  output logic [N_SW-1:0] sw_change,
  output logic            ready
);

  localparam int TDIV = tick_div(CLK_HZ);
  localparam int PW   = cnt_w(TDIV - 1);
  localparam int IW   = cnt_w(DEBOUNCE_MS);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          run;
  dbm_state_e    state, state_nxt;
  logic [IW-1:0] init_cnt, init_cnt_nxt;
  logic [N_SW-1:0] sw_rise, sw_fall, sw_long_unused, sw_held_unused;

  assign tick = en && (pre_cnt == PW'(TDIV - 1));

  // 1 ms prescaler; en low holds the count so the tick phase is kept.
  always_ff @(posedge clk or posedge reset)
    if (reset)   pre_cnt <= '0;
    else if (en) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end

  // INIT lasts one debounce window so the flops settle on the real pin levels.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT:
        if (tick) begin
          if (init_cnt == IW'(DEBOUNCE_MS - 1)) begin
            state_nxt    = ST_RUN;
            init_cnt_nxt = '0;
          end else begin
            init_cnt_nxt = init_cnt + 1'b1;
          end
        end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run   = (state == ST_RUN);
  assign ready = run;

  for (genvar i = 0; i < N_PB; i++) begin : g_pb
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_PRESS_MS(LONG_PRESS_MS), .HAS_LONG(1'b1), .IDLE(PB_ACTIVE_LOW[i])
    ) u_chan (
      .clk(clk), .reset(reset), .run(run), .tick(tick), .pin(pbtn_in[i]),
      .db(pbtn_db[i]), .press_ev(pb_press[i]), .rel_ev(pb_release[i]),
      .long_ev(pb_long[i]), .held(pb_held[i])
    );
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_PRESS_MS(LONG_PRESS_MS), .HAS_LONG(1'b0), .IDLE(1'b0)
    ) u_chan (
      .clk(clk), .reset(reset), .run(run), .tick(tick), .pin(switch_in[j]),
      .db(swtch_db[j]), .press_ev(sw_rise[j]), .rel_ev(sw_fall[j]),
      .long_ev(sw_long_unused[j]), .held(sw_held_unused[j])
    );
  end

  assign sw_change = sw_rise | sw_fall;

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed checks of debounce_multi against a behavioural model.
module tb_debounce_multi;

  localparam int NPB = 6, NSW = 16, NCH = 22;
  localparam int TD = 10, DB = 4, LP = 10;
  localparam logic [NPB-1:0] PAL  = 6'b000001;
  localparam logic [NCH-1:0] IDLE = {16'h0, PAL};
  localparam logic [62:0]    RST_V = {PAL, 16'h0, 24'h0, 16'h0, 1'b0};

  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [NPB-1:0] pbtn_in = PAL;
  logic [NSW-1:0] switch_in = '0;
  logic [NPB-1:0] pbtn_db, pb_press, pb_release, pb_long, pb_held;
  logic [NSW-1:0] swtch_db, sw_change;
  logic ready;
  logic [62:0] obs;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_PB(NPB), .N_SW(NSW), .CLK_HZ(10000), .DEBOUNCE_MS(DB),
    .LONG_PRESS_MS(LP), .SYNC_STAGES(2), .PB_ACTIVE_LOW(PAL)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pbtn_in(pbtn_in), .switch_in(switch_in),
    .pbtn_db(pbtn_db), .swtch_db(swtch_db), .pb_press(pb_press),
    .pb_release(pb_release), .pb_long(pb_long), .pb_held(pb_held),
    .sw_change(sw_change), .ready(ready)
  );

  assign obs = {pbtn_db, swtch_db, pb_press, pb_release, pb_long, pb_held, sw_change, ready};

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_db, m_s;
  int             m_pend[NCH];
  int             m_hold[NPB];
  logic [NPB-1:0] m_held, m_press, m_rel, m_long;
  logic [NSW-1:0] m_chg;
  int             en_cnt, init_ticks;
  logic           m_tick, m_ready;
  logic [62:0]    exp_v;

  task automatic mdl_pack();
    exp_v = {m_db[5:0], m_db[21:6], m_press, m_rel, m_long, m_held, m_chg, m_ready};
  endtask

  task automatic mdl_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(IDLE);
    m_db = IDLE; m_s = IDLE;
    for (int c = 0; c < NCH; c++) m_pend[c] = 0;
    for (int b = 0; b < NPB; b++) m_hold[b] = 0;
    m_held = '0; m_press = '0; m_rel = '0; m_long = '0; m_chg = '0;
    en_cnt = 0; init_ticks = 0; m_tick = 1'b0; m_ready = 1'b0;
    mdl_pack();
  endtask

  task automatic mdl_step();
    logic [NCH-1:0] act_old, upd;
    logic run;
    m_tick = en && ((en_cnt % TD) == TD - 1);
    if (en) en_cnt++;
    hist.push_front({switch_in, pbtn_in});
    void'(hist.pop_back());
    m_s = hist[2];
    run = (init_ticks >= DB);
    act_old = m_db ^ IDLE;
    upd = '0;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!run) begin
        m_db[c] = m_s[c]; m_pend[c] = 0;
      end else if (m_s[c] == m_db[c]) begin
        m_pend[c] = 0;
      end else if (m_tick) begin
        m_pend[c]++;
        if (m_pend[c] == DB) begin
          m_db[c] = m_s[c]; m_pend[c] = 0; upd[c] = 1'b1;
        end
      end
    end
    for (int b = 0; b < NPB; b++) begin
      if (!run) begin
        m_hold[b] = 0; m_held[b] = 1'b0;
      end else if (upd[b]) begin
        if (m_db[b] != PAL[b]) m_press[b] = 1'b1;
        else begin m_rel[b] = 1'b1; m_hold[b] = 0; m_held[b] = 1'b0; end
      end else if (act_old[b] && m_tick && m_hold[b] < LP) begin
        m_hold[b]++;
        if (m_hold[b] == LP) begin m_long[b] = 1'b1; m_held[b] = 1'b1; end
      end
    end
    m_chg = upd[21:6];
    if (!run && m_tick) init_ticks++;
    m_ready = (init_ticks >= DB);
    mdl_pack();
  endtask

  // advance one clock, keep the model in step, return at the falling edge
  task automatic cyc();
    @(posedge clk);
    if (reset) mdl_reset(); else mdl_step();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rdy_at, sw_ev;
    reset = 1'b1; en = 1'b1; switch_in = 16'hA5A5; pbtn_in = PAL;
    mdl_reset();
    repeat (3) @(negedge clk);
    total++; if (obs !== RST_V) begin bad++; $display("FAIL reset_values got=%h exp=%h", obs, RST_V); end
    reset = 1'b0;
    rdy_at = -1; sw_ev = 0;
    for (int i = 1; i <= 45; i++) begin
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL init_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (ready && rdy_at < 0) rdy_at = i;
      if (sw_change != '0) sw_ev++;
    end
    total++; if (rdy_at != 40) begin bad++; $display("FAIL ready_time got=%0d exp=40", rdy_at); end
    total++; if (swtch_db !== 16'hA5A5) begin bad++; $display("FAIL init_swtch got=%h exp=a5a5", swtch_db); end
    total++; if (sw_ev != 0) begin bad++; $display("FAIL init_no_change got=%0d exp=0", sw_ev); end
  endtask

  task automatic test_press_clean();
    int n_press, n_rel, tk, press_tk;
    logic s_seen;
    n_press = 0; n_rel = 0; tk = 0; press_tk = -1; s_seen = 1'b0;
    pbtn_in[5] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL press_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (m_s[5]) s_seen = 1'b1;
      if (s_seen && m_tick) tk++;
      if (pb_press[5]) begin n_press++; press_tk = tk; end
      if (pb_release[5]) n_rel++;
    end
    total++; if (n_press != 1 || n_rel != 0) begin bad++; $display("FAIL press_count got=%0d/%0d exp=1/0", n_press, n_rel); end
    total++; if (press_tk != DB) begin bad++; $display("FAIL press_ticks got=%0d exp=%0d", press_tk, DB); end
    total++; if (pbtn_db[5] !== 1'b1) begin bad++; $display("FAIL press_level got=%b exp=1", pbtn_db[5]); end
  endtask

  task automatic test_bounce();
    int ev;
    pbtn_in[5] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL unpress_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    ev = 0;
    for (int i = 0; i < 260; i++) begin
      if (i < 200 && (i % 15) == 0) pbtn_in[5] = ~pbtn_in[5];
      if (i == 200) pbtn_in[5] = 1'b0;
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL bounce_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (pb_press[5] || pb_release[5] || pbtn_db[5]) ev++;
    end
    total++; if (ev != 0) begin bad++; $display("FAIL bounce_events got=%0d exp=0", ev); end
  endtask

  task automatic test_long();
    int n_press, n_long, n_rel, press_at, long_at;
    logic prev_held, held_rel, prev_rel;
    n_press = 0; n_long = 0; n_rel = 0; press_at = -1; long_at = -1;
    prev_held = 1'b0; held_rel = 1'b1; prev_rel = 1'b0;
    pbtn_in[0] = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (i == 121) pbtn_in[0] = 1'b1;
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL long_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (pb_press[0]) begin n_press++; press_at = i; end
      if (pb_long[0])  begin n_long++;  long_at = i; end
      if (pb_release[0]) begin n_rel++; held_rel = pb_held[0]; prev_rel = prev_held; end
      prev_held = pb_held[0];
    end
    total++; if (n_press != 1 || n_long != 1 || n_rel != 1) begin
      bad++; $display("FAIL long_counts got=%0d/%0d/%0d exp=1/1/1", n_press, n_long, n_rel); end
    total++; if (long_at - press_at != LP * TD) begin
      bad++; $display("FAIL long_delay got=%0d exp=%0d", long_at - press_at, LP * TD); end
    total++; if (held_rel !== 1'b0 || prev_rel !== 1'b1) begin
      bad++; $display("FAIL held_clear got=%b%b exp=10", prev_rel, held_rel); end
  endtask

  task automatic test_enable();
    int n;
    logic got;
    switch_in[3] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL en_pre_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      total++; if (swtch_db[3] !== 1'b0 || sw_change !== '0) begin
        bad++; $display("FAIL en_freeze cyc=%0d got=%b exp=0", i, swtch_db[3]); end
    end
    en = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 60) begin
      cyc(); n++;
      total++; if (obs !== exp_v) begin bad++; $display("FAIL en_post_model cyc=%0d got=%h exp=%h", n, obs, exp_v); end
      if (sw_change[3]) got = 1'b1;
    end
    total++; if (!got || n > 2 * TD) begin bad++; $display("FAIL en_resume got=%0d exp<=%0d", n, 2 * TD); end
    total++; if (swtch_db[3] !== 1'b1) begin bad++; $display("FAIL en_level got=%b exp=1", swtch_db[3]); end
  endtask

  task automatic test_reset_mid();
    int n, rdy_at, sw_ev;
    switch_in[0] = 1'b0;
    n = 0;
    while (m_pend[6] != 3 && n < 80) begin
      cyc(); n++;
      total++; if (obs !== exp_v) begin bad++; $display("FAIL mid_model cyc=%0d got=%h exp=%h", n, obs, exp_v); end
    end
    total++; if (m_pend[6] != 3) begin bad++; $display("FAIL mid_reach got=%0d exp=3", m_pend[6]); end
    #2 reset = 1'b1; mdl_reset();
    #1;
    total++; if (obs !== RST_V) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, RST_V); end
    cyc(); cyc();
    reset = 1'b0;
    rdy_at = -1; sw_ev = 0;
    for (int i = 1; i <= 45; i++) begin
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL reinit_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (ready && rdy_at < 0) rdy_at = i;
      if (sw_change != '0) sw_ev++;
    end
    total++; if (rdy_at != 40) begin bad++; $display("FAIL reinit_ready got=%0d exp=40", rdy_at); end
    total++; if (swtch_db !== switch_in || sw_ev != 0) begin
      bad++; $display("FAIL reinit_sw got=%h/%0d exp=%h/0", swtch_db, sw_ev, switch_in); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NPB; c++) if ($urandom_range(0, 59) == 0) pbtn_in[c] = ~pbtn_in[c];
      for (int c = 0; c < NSW; c++) if ($urandom_range(0, 59) == 0) switch_in[c] = ~switch_in[c];
      en = ($urandom_range(0, 15) != 0);
      cyc();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_press_clean();
    test_bounce();
    test_long();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
